// File: rtl/dm_subword.sv
// Single-port byte-addressed data memory with byte/half/word stores, extended sub-word
// loads, misalignment flag and a 1- or 2-cycle registered response pipeline.

module dm_lane #(
  parameter int AW = 7
) (
  input  logic          clka,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdat,
  output logic [7:0]    rdat
);
  logic [7:0] mem [2**AW];

  // Array is not reset; read is asynchronous so old data is seen on the write edge.
  always_ff @(posedge clka) begin
    if (we) mem[idx] <= wdat;
  end

  assign rdat = mem[idx];
endmodule

module dm_subword #(
  parameter int ADDR_W      = 7,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [1:0]        sizea,
  input  logic              signa,
  input  logic [ADDR_W+1:0] addra,
  input  logic [31:0]       dina,
  output logic [31:0]       douta,
  output logic              valida,
  output logic              erra
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sign;
    logic        err;
  } dm_req_t;

  function automatic logic [31:0] extend(logic [31:0] w, logic [1:0] off,
                                         logic [1:0] sz, logic sg);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (sz)
      2'b00:   extend = {{24{sg & s[7]}}, s[7:0]};
      2'b01:   extend = {{16{sg & s[15]}}, s[15:0]};
      default: extend = w;
    endcase
  endfunction

  logic [ADDR_W-1:0]             widx;
  logic [1:0]                    off;
  logic                          mis;
  logic                          wr;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     rword;
  logic [NUM_LANES-1:0][7:0]     wword;

  assign widx = addra[ADDR_W+1:2];
  assign off  = addra[1:0];
  assign mis  = (sizea == 2'b11) | ((sizea == 2'b01) & off[0]) |
                ((sizea == 2'b10) & (off != 2'b00));
  assign wr   = rsta_n & ena & wea & ~mis;

  always_comb begin
    case (sizea)
      2'b00:   wword = {4{dina[7:0]}};
      2'b01:   wword = {2{dina[15:0]}};
      default: wword = dina;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    assign lane_we[i] = wr & ((sizea == 2'b10) |
                              ((sizea == 2'b01) & (off[1] == LN[1])) |
                              ((sizea == 2'b00) & (off == LN)));
    dm_lane #(.AW(ADDR_W)) u_lane (
      .clka (clka),
      .we   (lane_we[i]),
      .idx  (widx),
      .wdat (wword[i]),
      .rdat (rword[i])
    );
  end

  // Write-first stores return the right-aligned store data, so it enters at offset 0.
  dm_req_t req0;
  dm_req_t req_f;
  logic    wret;

  assign wret = wea & (WRITE_FIRST != 0);

  always_comb begin
    req0      = '0;
    req0.word = wret ? dina : rword;
    req0.off  = wret ? 2'b00 : off;
    req0.size = sizea;
    req0.sign = signa;
    req0.err  = mis;
  end

  if (RD_LAT == 2) begin : g_lat2
    dm_req_t st1_q;
    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n)  st1_q <= '0;
      else if (ena) st1_q <= req0;
    end
    assign req_f = st1_q;
  end else begin : g_lat1
    assign req_f = req0;
  end

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT:0]   vld_pipe;

  assign vld_pipe = {vld_q, ena};

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      vld_q <= '0;
      douta <= '0;
      erra  <= 1'b0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      if (vld_pipe[RD_LAT-1]) begin
        douta <= req_f.err ? 32'h0 : extend(req_f.word, req_f.off, req_f.size, req_f.sign);
        erra  <= req_f.err;
      end
    end
  end

  assign valida = vld_q[RD_LAT-1];
endmodule

// File: tb/tb_dm_subword.sv
// Four dm_subword configurations (latency 1/2 x write-first 1/0) driven by one request
// stream and checked against an arithmetic memory model.

module tb_dm_subword;
  logic              clka = 1'b0;
  logic              rsta_n;
  logic              ena, wea, signa;
  logic [1:0]        sizea;
  logic [8:0]        addra;
  logic [31:0]       dina;
  logic [3:0][31:0]  dout;
  logic [3:0]        vld, err;

  always #5 clka = ~clka;

  // index 0: lat1/wf1, 1: lat2/wf1, 2: lat1/wf0, 3: lat2/wf0
  dm_subword #(.ADDR_W(7), .RD_LAT(1), .WRITE_FIRST(1)) u_d0 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .sizea(sizea), .signa(signa),
    .addra(addra), .dina(dina), .douta(dout[0]), .valida(vld[0]), .erra(err[0]));
  dm_subword #(.ADDR_W(7), .RD_LAT(2), .WRITE_FIRST(1)) u_d1 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .sizea(sizea), .signa(signa),
    .addra(addra), .dina(dina), .douta(dout[1]), .valida(vld[1]), .erra(err[1]));
  dm_subword #(.ADDR_W(7), .RD_LAT(1), .WRITE_FIRST(0)) u_d2 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .sizea(sizea), .signa(signa),
    .addra(addra), .dina(dina), .douta(dout[2]), .valida(vld[2]), .erra(err[2]));
  dm_subword #(.ADDR_W(7), .RD_LAT(2), .WRITE_FIRST(0)) u_d3 (
    .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .sizea(sizea), .signa(signa),
    .addra(addra), .dina(dina), .douta(dout[3]), .valida(vld[3]), .erra(err[3]));

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] mm   [128];
  logic [31:0] hold [4];
  rsp_t        prev [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mext(logic [31:0] sub, logic [1:0] sz, logic sg);
    if (sg && sz == 2'd0 && sub[7])  return sub | 32'hFFFF_FF00;
    if (sg && sz == 2'd1 && sub[15]) return sub | 32'hFFFF_0000;
    return sub;
  endfunction

  task automatic step(input logic en, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [8:0] ad, input logic [31:0] di);
    rsp_t        cur [2];
    logic [31:0] mask, old, nw;
    int          sh, wi;
    logic        mis;
    @(negedge clka);
    ena = en; wea = we; sizea = sz; signa = sg; addra = ad; dina = di;
    @(posedge clka);
    cur[0] = '0; cur[1] = '0;
    mis  = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = 8 * int'(ad[1:0]);
    wi   = int'(ad[8:2]);
    if (rsta_n && en) begin
      if (mis) begin
        cur[0] = '{1'b1, 1'b1, 32'h0};
        cur[1] = '{1'b1, 1'b1, 32'h0};
      end else begin
        old = (mm[wi] >> sh) & mask;
        nw  = di & mask;
        cur[0] = '{1'b1, 1'b0, mext(old, sz, sg)};
        cur[1] = '{1'b1, 1'b0, mext(we ? nw : old, sz, sg)};
        if (we) mm[wi] = (mm[wi] & ~(mask << sh)) | (nw << sh);
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      rsp_t e;
      int   wf;
      wf = (k < 2) ? 1 : 0;
      e  = (k % 2 == 1) ? prev[wf] : cur[wf];
      chk($sformatf("valida[%0d] t=%0t", k, $time), 32'(vld[k]), 32'(e.v));
      if (e.v) begin
        chk($sformatf("erra[%0d] t=%0t", k, $time), 32'(err[k]), 32'(e.e));
        hold[k] = e.d;
      end
      chk($sformatf("douta[%0d] t=%0t", k, $time), dout[k], hold[k]);
    end
    prev[0] = cur[0];
    prev[1] = cur[1];
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 9'h0, 32'h0);
  endtask

  task automatic reset_now();
    rsta_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valida[%0d]", k), 32'(vld[k]), 32'h0);
      chk($sformatf("rst_douta[%0d]", k), dout[k], 32'h0);
      chk($sformatf("rst_erra[%0d]", k), 32'(err[k]), 32'h0);
      hold[k] = 32'h0;
    end
    prev[0] = '0;
    prev[1] = '0;
  endtask

  task automatic release_rst();
    @(negedge clka);
    ena = 1'b0;
    rsta_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mm[i] = 32'h0;
    for (int k = 0; k < 4; k++) hold[k] = 32'h0;
    prev[0] = '0; prev[1] = '0;
    rsta_n = 1'b1; ena = 1'b0; wea = 1'b0; sizea = 2'd0; signa = 1'b0;
    addra = 9'h0; dina = 32'h0;
    #1;
    reset_now();
    @(negedge clka);
    release_rst();

    // word store/load, byte merge and extension
    step(1, 1, 2'd2, 0, 9'h10, 32'hDEAD_BEEF);
    step(1, 0, 2'd2, 0, 9'h10, 32'h0);
    chk("lw_10", dout[0], 32'hDEAD_BEEF);
    step(1, 1, 2'd0, 0, 9'h13, 32'h0000_0080);
    step(1, 0, 2'd0, 1, 9'h13, 32'h0);
    chk("lb_13", dout[0], 32'hFFFF_FF80);
    step(1, 0, 2'd0, 0, 9'h13, 32'h0);
    chk("lbu_13", dout[0], 32'h0000_0080);
    step(1, 0, 2'd2, 0, 9'h10, 32'h0);
    chk("lw_merged", dout[0], 32'h80AD_BEEF);
    step(1, 0, 2'd1, 1, 9'h12, 32'h0);
    chk("lh_12", dout[0], 32'hFFFF_80AD);

    // misaligned half store must not write
    step(1, 1, 2'd1, 0, 9'h11, 32'h0000_1234);
    chk("mis_err", 32'(err[0]), 32'h1);
    chk("mis_dout", dout[0], 32'h0);
    step(1, 0, 2'd2, 0, 9'h10, 32'h0);
    chk("lw_after_mis", dout[0], 32'h80AD_BEEF);
    step(1, 0, 2'd2, 0, 9'h12, 32'h0);
    step(1, 1, 2'd3, 0, 9'h14, 32'hFFFF_FFFF);

    // pipelined stream on the latency-2 instances
    for (int i = 0; i < 4; i++) step(1, 1, 2'd2, 0, 9'(4 * i), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 2'd2, 0, 9'(4 * i), 32'h0);
      if (i > 0) chk($sformatf("stream%0d", i), dout[1], 32'(i));
    end
    idle();
    chk("stream3", dout[1], 32'h4);
    chk("stream_last_vld", 32'(vld[1]), 32'h1);
    idle();
    chk("stream_done", 32'(vld[1]), 32'h0);

    // write-return mode
    step(1, 1, 2'd2, 0, 9'h20, 32'h1122_3344);
    step(1, 1, 2'd0, 0, 9'h20, 32'h0000_00AA);
    chk("wf0_old", dout[2], 32'h0000_0044);
    chk("wf1_new", dout[0], 32'h0000_00AA);
    step(1, 1, 2'd1, 1, 9'h22, 32'h0000_9876);

    // randomized traffic over a preloaded region
    for (int i = 0; i < 16; i++) step(1, 1, 2'd2, 0, 9'(4 * i), $urandom);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(3) != 0), 1'($urandom_range(1)), 2'($urandom_range(3)),
           1'($urandom_range(1)), 9'($urandom_range(63)), $urandom);

    // reset with a response in flight
    step(1, 1, 2'd2, 0, 9'h10, 32'hCAFE_F00D);
    step(1, 0, 2'd2, 0, 9'h10, 32'h0);
    #2;
    reset_now();
    step(1, 1, 2'd2, 0, 9'h10, 32'hFFFF_FFFF);
    release_rst();
    idle();
    idle();
    step(1, 0, 2'd2, 0, 9'h10, 32'h0);
    chk("lw_after_rst", dout[0], 32'hCAFE_F00D);
    idle();
    chk("lw_after_rst_lat2", dout[1], 32'hCAFE_F00D);
    idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
